// File: rtl/exec_mem_stage.sv
// Execute/memory slice: ALU control decode, 32-bit ALU, and a word-addressed
// data memory indexed by the ALU result (combinational read, synchronous write).
module exec_mem_stage #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic        op5,
    input  logic        funct7_5,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    output logic [2:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] read_data
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_index;
    logic          w_slt;

    // ALU control decode from main-decoder class and instruction fields
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b00:   alu_control = ALU_ADD;
            2'b01:   alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    assign w_slt = ($signed(src_a) < $signed(src_b));

    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {31'd0, w_slt};
            default: alu_result = 32'd0;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    // Byte offset and upper bits are dropped, so addresses wrap modulo DEPTH words
    assign w_index = alu_result[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (mem_write) begin
            r_mem[w_index] <= write_data;
        end
    end

    assign read_data = r_mem[w_index];

endmodule

// File: tb/tb_exec_mem_stage.sv
// Scoreboard bench for exec_mem_stage: the stimulus pushes expected outputs
// from an instruction-level reference model; a monitor pops and compares them.
module tb_exec_mem_stage;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 6;

    typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT} op_e;

    typedef struct {
        string       name;
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        z;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        op5 = 1'b0;
    logic        funct7_5 = 1'b0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        mem_write = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] read_data;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;

    exec_mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .funct3(funct3), .op5(op5),
        .funct7_5(funct7_5), .src_a(src_a), .src_b(src_b), .mem_write(mem_write),
        .write_data(write_data), .alu_control(alu_control), .alu_result(alu_result),
        .zero(zero), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // Which operation the instruction asks for
    function automatic op_e ref_op(input logic [1:0] aop, input logic [2:0] f3,
                                   input logic o5, input logic f7);
        if (aop == 2'd1) return OP_SUB;
        if (aop != 2'd2) return OP_ADD;
        case (f3)
            3'd0:    return (o5 && f7) ? OP_SUB : OP_ADD;
            3'd2:    return OP_SLT;
            3'd4:    return OP_XOR;
            3'd6:    return OP_OR;
            3'd7:    return OP_AND;
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic [2:0] ref_code(input op_e op);
        case (op)
            OP_SUB:  return 3'd1;
            OP_AND:  return 3'd2;
            OP_OR:   return 3'd3;
            OP_XOR:  return 3'd4;
            OP_SLT:  return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'(int'(a));
        longint sb_ = longint'(int'(b));
        case (op)
            OP_ADD:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            OP_SUB:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return (sa < sb_) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Called just after a rising edge: applies one operation, records the
    // expected response, then lets one clock edge pass.
    task automatic drive(input string name, input logic [1:0] aop, input logic [2:0] f3,
                         input logic o5, input logic f7, input logic [31:0] a,
                         input logic [31:0] b, input logic mw, input logic [31:0] wd,
                         input logic rst);
        exp_t        e;
        op_e         op;
        int unsigned idx;
        alu_op = aop; funct3 = f3; op5 = o5; funct7_5 = f7;
        src_a = a; src_b = b; mem_write = mw; write_data = wd; reset = rst;
        if (rst) foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        op     = ref_op(aop, f3, o5, f7);
        e.name = name;
        e.ctl  = ref_code(op);
        e.res  = ref_alu(op, a, b);
        e.z    = (e.res == 32'd0);
        idx    = (e.res / 4) % DEPTH;
        e.rd   = ref_mem[idx];
        sb.push_back(e);
        @(posedge clk);
        if (mw && !rst) ref_mem[idx] = wd;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, "alu_control", 32'(alu_control), 32'(e.ctl));
                check(e.name, "alu_result", alu_result, e.res);
                check(e.name, "zero", 32'(zero), 32'(e.z));
                check(e.name, "read_data", read_data, e.rd);
            end
        end
    end

    initial begin : stimulus
        int waited;
        foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        @(posedge clk); #1;
        drive("reset_hold", 2'd0, 3'd0, 0, 0, 32'h100, 32'h4, 0, 0, 1);
        drive("after_reset", 2'd0, 3'd0, 0, 0, 32'h100, 32'h4, 0, 0, 0);
        drive("dec_sub_r", 2'd2, 3'd0, 1, 1, 32'd9, 32'd4, 0, 0, 0);
        drive("dec_addi", 2'd2, 3'd0, 0, 1, 32'd9, 32'd4, 0, 0, 0);
        drive("dec_slt", 2'd2, 3'd2, 1, 0, 32'd3, 32'd4, 0, 0, 0);
        drive("dec_xor", 2'd2, 3'd4, 1, 0, 32'h0F0, 32'h0FF, 0, 0, 0);
        drive("dec_or", 2'd2, 3'd6, 1, 0, 32'h0F, 32'hF0, 0, 0, 0);
        drive("dec_and", 2'd2, 3'd7, 1, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0);
        drive("dec_branch", 2'd1, 3'd0, 0, 0, 32'd5, 32'd5, 0, 0, 0);
        drive("dec_op11", 2'd3, 3'd7, 1, 1, 32'd7, 32'd8, 0, 0, 0);
        drive("dec_f3_other", 2'd2, 3'd1, 1, 1, 32'd7, 32'd8, 0, 0, 0);
        drive("add_wrap", 2'd0, 3'd0, 0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
        drive("slt_neg", 2'd2, 3'd2, 1, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0);
        drive("slt_pos", 2'd2, 3'd2, 1, 0, 32'd1, 32'hFFFFFFFF, 0, 0, 0);
        drive("store_20", 2'd0, 3'd0, 0, 0, 32'h20, 32'd0, 1, 32'hDEADBEEF, 0);
        drive("load_20", 2'd0, 3'd0, 0, 0, 32'h20, 32'd0, 0, 0, 0);
        drive("load_23", 2'd0, 3'd0, 0, 0, 32'h20, 32'd3, 0, 0, 0);
        drive("load_120", 2'd0, 3'd0, 0, 0, 32'h100, 32'h20, 0, 0, 0);
        drive("raw_1", 2'd0, 3'd0, 0, 0, 32'h8, 32'd0, 1, 32'h11111111, 0);
        drive("raw_2", 2'd0, 3'd0, 0, 0, 32'h8, 32'd0, 1, 32'h22222222, 0);
        drive("raw_after", 2'd0, 3'd0, 0, 0, 32'h8, 32'd0, 0, 0, 0);
        drive("pre_rst_load", 2'd0, 3'd0, 0, 0, 32'h20, 32'd0, 0, 0, 0);
        drive("rst_mid_write", 2'd0, 3'd0, 0, 0, 32'h20, 32'd0, 1, 32'h77777777, 1);
        drive("post_rst_load", 2'd0, 3'd0, 0, 0, 32'h20, 32'd0, 0, 0, 0);
        drive("post_rst_raw", 2'd0, 3'd0, 0, 0, 32'h8, 32'd0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            drive("random", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b,
                  1'($urandom_range(0, 2) == 0), $urandom,
                  1'($urandom_range(0, 59) == 0));
        end
        mem_write = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_mem_stage.md
Name: exec_mem_stage

Overview:
- Combined execute/memory datapath slice for the single-issue RV32I pipeline.
- Contains an ALU control decoder, a 32-bit ALU, and a word-addressed data memory.
- The memory address is driven internally by the ALU result.
- Sits between the ID/EX and MEM/WB pipeline registers. The decoder and ALU are purely combinational; the memory write is synchronous.

Parameters:
- DEPTH, 64, number of 32-bit data memory words; must be a power of two.
- AW, 6, memory index width (log2 DEPTH).

Ports:
- clk  in  1  clock; memory writes on the rising edge.
- reset  in  1  reset, asynchronous, active-high; clears all memory words.
- alu_op  in  2  operation class from the main decoder.
- funct3  in  3  instr[14:12].
- op5  in  1  instr[5]; 1 = R-type, 0 = I-type.
- funct7_5  in  1  instr[30].
- src_a  in  32  ALU operand A (already forwarded).
- src_b  in  32  ALU operand B (register or immediate, already muxed).
- mem_write  in  1  data memory write enable.
- write_data  in  32  store data.
- alu_control  out  3  decoded ALU operation.
- alu_result  out  32  ALU result; also the memory byte address.
- zero  out  1  1 when alu_result == 0.
- read_data  out  32  memory word at alu_result.

Behaviour:
- Decoder, combinational:
  - alu_op 00 -> 000 (add; loads/stores).
  - alu_op 01 -> 001 (sub; branches).
  - alu_op 11 -> 000.
  - alu_op 10, decoded by funct3:
    - 000 -> 001 if op5 & funct7_5, else 000.
    - 010 -> 101 (slt).
    - 100 -> 100 (xor).
    - 110 -> 011 (or).
    - 111 -> 010 (and).
    - any other funct3 -> 000.
- ALU, combinational, 32-bit, driven by alu_control:
  - 000 a+b, modulo 2^32, no carry out.
  - 001 a-b, modulo 2^32.
  - 010 a&b.
  - 011 a|b.
  - 100 a^b.
  - 101 signed a<b ? 1 : 0, zero-extended.
  - 110, 111 -> 0.
- zero = (alu_result == 0), recomputed combinationally.
- Memory addressing:
  - Word index = alu_result[AW+1:2].
  - Bits [1:0] are ignored (no byte/half access, no misalign trap).
  - Upper address bits are ignored, so the address wraps modulo DEPTH words.
- Memory read: combinational; read_data = mem[index] at all times. No read enable.
- Memory write: on posedge clk with mem_write=1 and reset=0, mem[index] <= write_data. read_data reflects the new word immediately after that edge.
- Read and write to the same index in one cycle: read_data shows the old value before the edge and the new value after it. No bypass.
- Reset:
  - Asserting reset asynchronously clears every memory word to 0.
  - reset dominates mem_write.
  - Reset mid-operation discards any pending write.
  - After reset, read_data = 0 for all addresses.
  - alu_control, alu_result and zero depend only on inputs and are unaffected by reset.
- mem_write=0: memory contents hold indefinitely.
- No outputs are X for any defined input combination.

Test Plan:
- Reset, then mem_write=0, alu_op=00, src_a=0x100, src_b=0x4 -> alu_control=000, alu_result=0x104, zero=0, read_data=0.
- Decode sweep with alu_op=10:
  - funct3=000, op5=1, funct7_5=1 -> 001.
  - funct3=000, op5=0, funct7_5=1 -> 000.
  - funct3=010 -> 101; 100 -> 100; 110 -> 011; 111 -> 010.
  - alu_op=01 -> 001.
- ALU corners:
  - 0xFFFFFFFF+1 -> 0, zero=1.
  - sub 5-5 -> 0, zero=1.
  - slt 0xFFFFFFFF vs 1 -> 1; slt 1 vs 0xFFFFFFFF -> 0.
  - and 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
  - or 0x0F with 0xF0 -> 0xFF.
- Store/load: alu_op=00, src_a=0x20, src_b=0, write_data=0xDEADBEEF, mem_write=1 for one edge.
  - read_data=0xDEADBEEF after the edge.
  - With mem_write=0, address 0x23 -> 0xDEADBEEF (low bits ignored).
  - Address 0x20+4*DEPTH=0x120 -> 0xDEADBEEF (wrap).
- Same-cycle read/write: write 0x11111111 then 0x22222222 to 0x8 on consecutive edges -> read_data is 0x11111111 between the edges and 0x22222222 after the second.
- Reset mid-operation: with mem_write=1, pulse reset between clock edges -> read_data drops to 0 asynchronously, and the edge during reset performs no write.
